enemy_shot: RTL and testbench

Enemy-fire controller: the downward counterpart of the player-bullet block. It picks a living enemy column pseudo-randomly and spawns one shot below the lowest living enemy in that column. The shot moves down at a fixed rate, and a hit on the player ship decrements lives. The block also drives the shot's pixel colour for the VGA colour-combine stage. It sits beside the player ship and player-bullet blocks in the game top, fed by the VGA h/v counters and the enemy-alive vector.

---
 rtl/space_invaders_pkg.sv | 46 ++++
 rtl/lfsr8.sv | 20 ++
 rtl/enemy_shot.sv | 184 ++++++++++++++++++
 tb/tb_enemy_shot.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/space_invaders_pkg.sv
// Shared geometry, lookup helpers and the enemy-shot state type for the
// Space Invaders game blocks (enemy grid, ship, player bullet, enemy shot).
package space_invaders_pkg;

  localparam logic [9:0] ENEMY_W  = 10'd32;
  localparam logic [9:0] ENEMY_H  = 10'd32;
  localparam logic [9:0] SHOT_W   = 10'd4;
  localparam logic [9:0] SHOT_H   = 10'd8;
  localparam logic [9:0] SHIP_Y   = 10'd440;
  localparam logic [9:0] SHIP_W   = 10'd40;
  localparam logic [9:0] SHIP_H   = 10'd20;
  localparam logic [9:0] SCREEN_H = 10'd480;

  // Enemy shot controller states
  typedef enum logic [2:0] {
    ST_COOLDOWN,
    ST_SELECT,
    ST_FLYING,
    ST_HIT,
    ST_DEAD
  } shot_state_t;

  // Left edge of an enemy column, taken from a constant table
  function automatic logic [9:0] col_x(input logic [2:0] col);
    case (col)
      3'd0:    col_x = 10'd180;
      3'd1:    col_x = 10'd260;
      3'd2:    col_x = 10'd340;
      3'd3:    col_x = 10'd420;
      3'd4:    col_x = 10'd500;
      3'd5:    col_x = 10'd580;
      3'd6:    col_x = 10'd660;
      default: col_x = 10'd740;
    endcase
  endfunction

  // Top edge of an enemy row
  function automatic logic [9:0] row_y(input logic [1:0] row);
    case (row)
      2'd1:    row_y = 10'd90;
      2'd2:    row_y = 10'd140;
      default: row_y = 10'd40;
    endcase
  endfunction

endpackage

// File: rtl/lfsr8.sv
// Seedable 8-bit Fibonacci LFSR (taps 8,6,5,4), advancing every clock.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] q
);

  logic feedback;

  assign feedback = q[7] ^ q[5] ^ q[4] ^ q[3];

  // Shift left and insert the tap XOR; reset restores the seed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) q <= SEED;
    else       q <= {q[6:0], feedback};
  end

endmodule

// File: rtl/enemy_shot.sv
// Enemy-fire controller: picks a living column, drops one shot below the
// lowest living enemy in it, moves it down, and scores hits on the player.
module enemy_shot
  import space_invaders_pkg::*;
#(
  parameter int unsigned COOLDOWN_CYC = 25_000_000,
  parameter int unsigned MOVE_DIV     = 200_000,
  parameter int unsigned STEP         = 1,
  parameter int unsigned LIVES        = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  input  logic [23:0] enemy_alive,
  input  logic [9:0]  posX_Nave,
  output logic        shot_active,
  output logic [9:0]  posX_shot,
  output logic [9:0]  posY_shot,
  output logic        player_hit,
  output logic [1:0]  lives,
  output logic        vivo_jogador,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B
);

  localparam logic [31:0] COOL_LAST  = 32'(COOLDOWN_CYC - 1);
  localparam logic [31:0] MOVE_LAST  = 32'(MOVE_DIV - 1);
  localparam logic [9:0]  STEP_PX    = 10'(STEP);
  localparam logic [1:0]  LIVES_INIT = 2'(LIVES);
  localparam logic [9:0]  SHOT_XOFF  = 10'd14;

  shot_state_t state, state_next;
  logic [31:0] cnt, cnt_next;
  logic [2:0]  col, col_next, tries, tries_next;
  logic [9:0]  pos_x_next, pos_y_next;
  logic        active_next, hit_next;
  logic [1:0]  lives_next;
  logic [7:0]  lfsr_q;
  logic        col_alive, overlap, pixel_on;
  logic [9:0]  spawn_y, ny;
  logic [10:0] ship_right, shot_right, shot_bottom, ny_bottom;

  lfsr8 #(.SEED(8'hA5)) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .q     (lfsr_q)
  );

  assign col_alive = enemy_alive[{2'd0, col}] | enemy_alive[{2'd1, col}] |
                     enemy_alive[{2'd2, col}];
  assign spawn_y   = enemy_alive[{2'd2, col}] ? row_y(2'd2) + ENEMY_H :
                     enemy_alive[{2'd1, col}] ? row_y(2'd1) + ENEMY_H :
                                                row_y(2'd0) + ENEMY_H;

  assign ny          = posY_shot + STEP_PX;
  assign ship_right  = {1'b0, posX_Nave} + {1'b0, SHIP_W};
  assign shot_right  = {1'b0, posX_shot} + {1'b0, SHOT_W};
  assign shot_bottom = {1'b0, posY_shot} + {1'b0, SHOT_H};
  assign ny_bottom   = {1'b0, ny} + {1'b0, SHOT_H};
  assign overlap     = ({1'b0, posX_shot} < ship_right) &&
                       ({1'b0, posX_Nave} < shot_right) &&
                       (ny < SHIP_Y + SHIP_H) &&
                       ({1'b0, SHIP_Y} < ny_bottom);

  assign vivo_jogador = (lives != 2'd0);

  // FSM state register; reset drops back into cooldown
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_COOLDOWN;
    else       state <= state_next;
  end

  // Next-state and datapath updates; the hit test outranks the bottom test
  always_comb begin
    state_next  = state;
    cnt_next    = cnt;
    col_next    = col;
    tries_next  = tries;
    pos_x_next  = posX_shot;
    pos_y_next  = posY_shot;
    active_next = shot_active;
    hit_next    = 1'b0;
    lives_next  = lives;
    case (state)
      ST_COOLDOWN: begin
        if (cnt == COOL_LAST) begin
          state_next = ST_SELECT;
          cnt_next   = 32'd0;
          col_next   = lfsr_q[2:0];
          tries_next = 3'd0;
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      ST_SELECT: begin
        if (col_alive) begin
          pos_x_next  = col_x(col) + SHOT_XOFF;
          pos_y_next  = spawn_y;
          active_next = 1'b1;
          cnt_next    = 32'd0;
          state_next  = ST_FLYING;
        end else if (tries == 3'd7) begin
          cnt_next   = 32'd0;
          state_next = ST_COOLDOWN;
        end else begin
          col_next   = col + 3'd1;
          tries_next = tries + 3'd1;
        end
      end
      ST_FLYING: begin
        if (cnt == MOVE_LAST) begin
          cnt_next = 32'd0;
          if (overlap) begin
            state_next  = ST_HIT;
            hit_next    = 1'b1;
            active_next = 1'b0;
            lives_next  = (lives == 2'd0) ? 2'd0 : lives - 2'd1;
          end else if (ny > SCREEN_H - SHOT_H) begin
            state_next  = ST_COOLDOWN;
            active_next = 1'b0;
          end else begin
            pos_y_next = ny;
          end
        end else begin
          cnt_next = cnt + 32'd1;
        end
      end
      ST_HIT: begin
        cnt_next   = 32'd0;
        state_next = (lives == 2'd0) ? ST_DEAD : ST_COOLDOWN;
      end
      ST_DEAD: begin
        state_next = ST_DEAD;
      end
      default: begin
        state_next = ST_COOLDOWN;
        cnt_next   = 32'd0;
      end
    endcase
  end

  // Datapath registers: counters, shot position, hit pulse and lives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= 32'd0;
      col         <= 3'd0;
      tries       <= 3'd0;
      posX_shot   <= 10'd0;
      posY_shot   <= 10'd0;
      shot_active <= 1'b0;
      player_hit  <= 1'b0;
      lives       <= LIVES_INIT;
    end else begin
      cnt         <= cnt_next;
      col         <= col_next;
      tries       <= tries_next;
      posX_shot   <= pos_x_next;
      posY_shot   <= pos_y_next;
      shot_active <= active_next;
      player_hit  <= hit_next;
      lives       <= lives_next;
    end
  end

  assign pixel_on = shot_active &&
                    (h_counter >= posX_shot) && ({1'b0, h_counter} < shot_right) &&
                    (v_counter >= posY_shot) && ({1'b0, v_counter} < shot_bottom);

  // Registered shot colour: yellow inside the shot, black elsewhere
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      R <= 8'h00;
      G <= 8'h00;
      B <= 8'h00;
    end else begin
      R <= pixel_on ? 8'hFF : 8'h00;
      G <= pixel_on ? 8'hFF : 8'h00;
      B <= 8'h00;
    end
  end

endmodule

// File: tb/tb_enemy_shot.sv
// Directed self-checking bench for enemy_shot with short cooldown and step period.
module tb_enemy_shot;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  h_counter, v_counter, posX_Nave;
  logic [23:0] enemy_alive;
  logic        shot_active, player_hit, vivo_jogador;
  logic [9:0]  posX_shot, posY_shot;
  logic [1:0]  lives;
  logic [7:0]  R, G, B;

  int testCount = 0;
  int failCount = 0;

  localparam logic [23:0] ALIVE_R1C5 = 24'h00_2000;

  enemy_shot #(
    .COOLDOWN_CYC (4),
    .MOVE_DIV     (2),
    .STEP         (1),
    .LIVES        (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .h_counter    (h_counter),
    .v_counter    (v_counter),
    .enemy_alive  (enemy_alive),
    .posX_Nave    (posX_Nave),
    .shot_active  (shot_active),
    .posX_shot    (posX_shot),
    .posY_shot    (posY_shot),
    .player_hit   (player_hit),
    .lives        (lives),
    .vivo_jogador (vivo_jogador),
    .R            (R),
    .G            (G),
    .B            (B)
  );

  // 100 MHz bench clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] alive, input logic [9:0] ship,
                               input logic [9:0] h, input logic [9:0] v);
    enemy_alive = alive;
    posX_Nave   = ship;
    h_counter   = h;
    v_counter   = v;
  endtask

  task automatic waitSpawn(output int cyc);
    cyc = 0;
    while (!shot_active && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic waitHit(output int cyc);
    cyc = 0;
    while (!player_hit && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    int  cyc;
    logic sawHit, sawActive;

    // Reset values
    applyStimulus(ALIVE_R1C5, 10'd592, 10'd0, 10'd0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst shot_active", 32'(shot_active), 32'd0);
    checkOutput("rst posX_shot", 32'(posX_shot), 32'd0);
    checkOutput("rst posY_shot", 32'(posY_shot), 32'd0);
    checkOutput("rst player_hit", 32'(player_hit), 32'd0);
    checkOutput("rst lives", 32'(lives), 32'd3);
    checkOutput("rst vivo", 32'(vivo_jogador), 32'd1);
    checkOutput("rst RGB", 32'({R, G, B}), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // First shot: latency, spawn position, hit after 311 steps
    waitSpawn(cyc);
    checkOutput("spawn seen", 32'(shot_active), 32'd1);
    checkOutput("spawn latency in 5..12", 32'(cyc >= 5 && cyc <= 12), 32'd1);
    checkOutput("spawn posX", 32'(posX_shot), 32'd594);
    checkOutput("spawn posY", 32'(posY_shot), 32'd122);
    waitHit(cyc);
    checkOutput("hit seen", 32'(player_hit), 32'd1);
    checkOutput("hit lives", 32'(lives), 32'd2);
    checkOutput("hit vivo", 32'(vivo_jogador), 32'd1);
    checkOutput("hit last posY", 32'(posY_shot), 32'd432);
    @(negedge clk);
    checkOutput("hit single pulse", 32'(player_hit), 32'd0);
    checkOutput("hit shot cleared", 32'(shot_active), 32'd0);

    // Reset in mid-flight with lives at 2
    waitSpawn(cyc);
    repeat (20) @(negedge clk);
    checkOutput("midflight active", 32'(shot_active), 32'd1);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst shot_active", 32'(shot_active), 32'd0);
    checkOutput("midrst lives", 32'(lives), 32'd3);
    checkOutput("midrst player_hit", 32'(player_hit), 32'd0);
    @(negedge clk);
    checkOutput("midrst player_hit later", 32'(player_hit), 32'd0);
    reset = 1'b0;

    // Three consecutive hits down to zero lives
    for (int i = 1; i <= 3; i++) begin
      waitSpawn(cyc);
      checkOutput("3hit spawn posY", 32'(posY_shot), 32'd122);
      waitHit(cyc);
      checkOutput("3hit seen", 32'(player_hit), 32'd1);
      checkOutput("3hit lives", 32'(lives), 32'(3 - i));
      checkOutput("3hit vivo", 32'(vivo_jogador), 32'(i < 3));
      @(negedge clk);
      checkOutput("3hit pulse end", 32'(player_hit), 32'd0);
    end
    sawActive = 1'b0;
    sawHit    = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      sawActive |= shot_active;
      sawHit    |= player_hit;
    end
    checkOutput("dead no spawn", 32'(sawActive), 32'd0);
    checkOutput("dead no hit", 32'(sawHit), 32'd0);
    checkOutput("dead lives", 32'(lives), 32'd0);
    checkOutput("dead vivo", 32'(vivo_jogador), 32'd0);

    // No living enemies: never fires
    reset = 1'b1;
    applyStimulus(24'h0, 10'd592, 10'd0, 10'd0);
    @(negedge clk);
    reset = 1'b0;
    sawActive = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      sawActive |= shot_active;
    end
    checkOutput("empty grid no shot", 32'(sawActive), 32'd0);
    checkOutput("empty grid lives", 32'(lives), 32'd3);

    // Miss: shot reaches the bottom; pixel colour checked on the way
    reset = 1'b1;
    applyStimulus(ALIVE_R1C5, 10'd100, 10'd0, 10'd203);
    @(negedge clk);
    reset = 1'b0;
    waitSpawn(cyc);
    checkOutput("miss spawn posX", 32'(posX_shot), 32'd594);
    cyc = 0;
    while (posY_shot != 10'd200 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("pixel sync posY", 32'(posY_shot), 32'd200);
    checkOutput("pixel h=0 black", 32'({R, G, B}), 32'd0);
    for (int h = 594; h <= 598; h++) begin
      h_counter = 10'(h);
      @(negedge clk);
      checkOutput($sformatf("pixel h=%0d", h), 32'({R, G, B}),
                  (h <= 597) ? 32'hFFFF00 : 32'd0);
    end
    h_counter = 10'd0;
    sawHit = 1'b0;
    cyc    = 0;
    while (shot_active && cyc < 2000) begin
      @(negedge clk);
      sawHit |= player_hit;
      cyc++;
    end
    checkOutput("miss despawned", 32'(shot_active), 32'd0);
    checkOutput("miss last posY", 32'(posY_shot), 32'd472);
    checkOutput("miss no hit", 32'(sawHit), 32'd0);
    checkOutput("miss lives", 32'(lives), 32'd3);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
